// File: rtl/id_ex_fwd.sv
// ---------------------------------------------------------------------------
// id_ex_fwd
//   ID/EX pipeline register that sits directly in front of the execute stage.
//   Every edge, it captures the decoded instruction and its operands from ID.
//   When the instruction reads a register that EX is writing this same cycle,
//   the register-file operand is replaced by the EX result before capture.
//   The ctrl jump (flush) and hold (stall) requests are honoured here.
//   Two saturating event counters count flushes and forwarded operands.
//
// Parameters
//   NOP_INST : instruction word loaded on reset or flush (addi x0,x0,0).
//   CNT_W    : width of the saturating event counters (must be >= 2).
//
// Ports
//   clk, rst                 : clock (rising edge); asynchronous active-low reset.
//   inst_i, inst_addr_i      : instruction word and its address from ID.
//   op1_i, op2_i             : operands from ID (rs1 value; rs2 value or immediate).
//   rs1_addr_i, rs2_addr_i   : source register indices of the ID instruction.
//   rd_addr_i, rd_wen_i      : destination index and write enable from ID.
//   ex_rd_addr_i/_data_i/_wen_i : EX result bus. It is combinational out of EX,
//                              so it is only ever used on the D side of the registers.
//   jump_en_i, hold_flag_i   : ctrl flush / stall requests.
//   inst_o .. rd_wen_o       : registered instruction fields presented to EX.
//   valid_o                  : 1 = real instruction held, 0 = bubble.
//   flush_cnt_o, fwd_cnt_o   : saturating flush-cycle and forwarded-operand counts.
// ---------------------------------------------------------------------------
module id_ex_fwd #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_i,
    input  logic [31:0]      inst_addr_i,
    input  logic [31:0]      op1_i,
    input  logic [31:0]      op2_i,
    input  logic [4:0]       rs1_addr_i,
    input  logic [4:0]       rs2_addr_i,
    input  logic [4:0]       rd_addr_i,
    input  logic             rd_wen_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic [31:0]      ex_rd_data_i,
    input  logic             ex_rd_wen_i,
    input  logic             jump_en_i,
    input  logic             hold_flag_i,
    output logic [31:0]      inst_o,
    output logic [31:0]      inst_addr_o,
    output logic [31:0]      op1_o,
    output logic [31:0]      op2_o,
    output logic [4:0]       rd_addr_o,
    output logic             rd_wen_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] fwd_cnt_o
);

    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_B = 7'b1100011;

    // Add a small increment (0..2) and clamp at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
        if (sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end
        return sum[CNT_W-1:0];
    endfunction

    logic [6:0]  opcode;
    logic        use_rs1;
    logic        use_rs2;
    logic        fwd1;
    logic        fwd2;
    logic [31:0] op1_fwd;
    logic [31:0] op2_fwd;
    logic [1:0]  fwd_inc;

    logic [31:0]      inst_p1;
    logic [31:0]      inst_addr_p1;
    logic [31:0]      op1_p1;
    logic [31:0]      op2_p1;
    logic [4:0]       rd_addr_p1;
    logic             rd_wen_p1;
    logic             vld_p1;
    logic [CNT_W-1:0] flush_cnt_p1;
    logic [CNT_W-1:0] fwd_cnt_p1;

    // ---- ID side: forwarding decode on the incoming instruction ----
    // op2 of an I-type is an immediate, so only R and B types may forward rs2.
    // x0 is hard-wired zero and is never forwarded.
    always_comb begin
        opcode  = inst_i[6:0];
        use_rs1 = (opcode == OPC_I) || (opcode == OPC_R) || (opcode == OPC_B);
        use_rs2 = (opcode == OPC_R) || (opcode == OPC_B);
        fwd1    = use_rs1 && ex_rd_wen_i && (ex_rd_addr_i != 5'd0)
                  && (ex_rd_addr_i == rs1_addr_i);
        fwd2    = use_rs2 && ex_rd_wen_i && (ex_rd_addr_i != 5'd0)
                  && (ex_rd_addr_i == rs2_addr_i);
        op1_fwd = fwd1 ? ex_rd_data_i : op1_i;
        op2_fwd = fwd2 ? ex_rd_data_i : op2_i;
        fwd_inc = {1'b0, fwd1} + {1'b0, fwd2};
    end

    // ---- ID/EX register: jump beats hold, hold beats load ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_p1      <= NOP_INST;
            inst_addr_p1 <= 32'd0;
            op1_p1       <= 32'd0;
            op2_p1       <= 32'd0;
            rd_addr_p1   <= 5'd0;
            rd_wen_p1    <= 1'b0;
            vld_p1       <= 1'b0;
            flush_cnt_p1 <= '0;
            fwd_cnt_p1   <= '0;
        end else if (jump_en_i) begin
            inst_p1      <= NOP_INST;
            inst_addr_p1 <= 32'd0;
            op1_p1       <= 32'd0;
            op2_p1       <= 32'd0;
            rd_addr_p1   <= 5'd0;
            rd_wen_p1    <= 1'b0;
            vld_p1       <= 1'b0;
            flush_cnt_p1 <= sat_add(flush_cnt_p1, 2'd1);
        end else if (!hold_flag_i) begin
            inst_p1      <= inst_i;
            inst_addr_p1 <= inst_addr_i;
            op1_p1       <= op1_fwd;
            op2_p1       <= op2_fwd;
            rd_addr_p1   <= rd_addr_i;
            rd_wen_p1    <= rd_wen_i;
            vld_p1       <= 1'b1;
            fwd_cnt_p1   <= sat_add(fwd_cnt_p1, fwd_inc);
        end
    end

    // ---- EX side: registered outputs only ----
    assign inst_o      = inst_p1;
    assign inst_addr_o = inst_addr_p1;
    assign op1_o       = op1_p1;
    assign op2_o       = op2_p1;
    assign rd_addr_o   = rd_addr_p1;
    assign rd_wen_o    = rd_wen_p1;
    assign valid_o     = vld_p1;
    assign flush_cnt_o = flush_cnt_p1;
    assign fwd_cnt_o   = fwd_cnt_p1;

endmodule

// File: tb/tb_id_ex_fwd.sv
// ---------------------------------------------------------------------------
// tb_id_ex_fwd
//   Directed bench for id_ex_fwd. A table of one-cycle vectors (inputs plus
//   hand-computed registered outputs and cumulative counter values) is applied
//   in order. Hand-written sequences then cover counter saturation on a
//   CNT_W=4 instance and an asynchronous reset asserted during a hold.
// ---------------------------------------------------------------------------
module tb_id_ex_fwd;

    logic        clk;
    logic        rst;
    logic [31:0] inst_i, inst_addr_i, op1_i, op2_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic        rd_wen_i;
    logic [4:0]  ex_rd_addr_i;
    logic [31:0] ex_rd_data_i;
    logic        ex_rd_wen_i;
    logic        jump_en_i, hold_flag_i;

    logic [31:0] inst_o, inst_addr_o, op1_o, op2_o;
    logic [4:0]  rd_addr_o;
    logic        rd_wen_o, valid_o;
    logic [15:0] flush_cnt_o, fwd_cnt_o;

    logic [31:0] s_inst_o, s_inst_addr_o, s_op1_o, s_op2_o;
    logic [4:0]  s_rd_addr_o;
    logic        s_rd_wen_o, s_valid_o;
    logic [3:0]  s_flush_cnt_o, s_fwd_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_fwd dut (
        .clk(clk), .rst(rst),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i), .op2_i(op2_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rd_addr_i(rd_addr_i), .rd_wen_i(rd_wen_i),
        .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_data_i(ex_rd_data_i), .ex_rd_wen_i(ex_rd_wen_i),
        .jump_en_i(jump_en_i), .hold_flag_i(hold_flag_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o),
        .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o), .valid_o(valid_o),
        .flush_cnt_o(flush_cnt_o), .fwd_cnt_o(fwd_cnt_o)
    );

    id_ex_fwd #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i), .op2_i(op2_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rd_addr_i(rd_addr_i), .rd_wen_i(rd_wen_i),
        .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_data_i(ex_rd_data_i), .ex_rd_wen_i(ex_rd_wen_i),
        .jump_en_i(jump_en_i), .hold_flag_i(hold_flag_i),
        .inst_o(s_inst_o), .inst_addr_o(s_inst_addr_o), .op1_o(s_op1_o), .op2_o(s_op2_o),
        .rd_addr_o(s_rd_addr_o), .rd_wen_o(s_rd_wen_o), .valid_o(s_valid_o),
        .flush_cnt_o(s_flush_cnt_o), .fwd_cnt_o(s_fwd_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wen;
        logic [4:0]  exa;
        logic [31:0] exd;
        logic        exw;
        logic        jmp;
        logic        hld;
        logic [31:0] e_inst;
        logic [31:0] e_addr;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic [4:0]  e_rd;
        logic        e_wen;
        logic        e_vld;
        logic [15:0] e_fc;
        logic [15:0] e_wc;
    } vec_t;

    localparam int NV = 15;
    vec_t vec [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        inst_i       = v.inst;
        inst_addr_i  = v.addr;
        op1_i        = v.op1;
        op2_i        = v.op2;
        rs1_addr_i   = v.rs1;
        rs2_addr_i   = v.rs2;
        rd_addr_i    = v.rd;
        rd_wen_i     = v.wen;
        ex_rd_addr_i = v.exa;
        ex_rd_data_i = v.exd;
        ex_rd_wen_i  = v.exw;
        jump_en_i    = v.jmp;
        hold_flag_i  = v.hld;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".inst"},  inst_o, 32'h0000_0013);
        chk({tag, ".addr"},  inst_addr_o, 32'h0);
        chk({tag, ".op1"},   op1_o, 32'h0);
        chk({tag, ".op2"},   op2_o, 32'h0);
        chk({tag, ".rd"},    32'(rd_addr_o), 32'h0);
        chk({tag, ".wen"},   32'(rd_wen_o), 32'h0);
        chk({tag, ".valid"}, 32'(valid_o), 32'h0);
        chk({tag, ".fcnt"},  32'(flush_cnt_o), 32'h0);
        chk({tag, ".wcnt"},  32'(fwd_cnt_o), 32'h0);
    endtask

    vec_t idle;
    vec_t bne4;

    initial begin
        // inst, addr, op1, op2, rs1, rs2, rd, wen, exa, exd, exw, jmp, hld,
        // e_inst, e_addr, e_op1, e_op2, e_rd, e_wen, e_vld, e_fc, e_wc
        // addi x1,x0,5
        vec[0]  = '{32'h0050_0093, 32'h00, 32'h0, 32'h5, 5'd0, 5'd5, 5'd1, 1'b1, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0,
                    32'h0050_0093, 32'h00, 32'h0, 32'h5, 5'd1, 1'b1, 1'b1, 16'd0, 16'd0};
        // add x3,x1,x2 with EX writing x1 -> rs1 forwarded
        vec[1]  = '{32'h0020_81B3, 32'h04, 32'h0, 32'h7, 5'd1, 5'd2, 5'd3, 1'b1, 5'd1, 32'h10, 1'b1, 1'b0, 1'b0,
                    32'h0020_81B3, 32'h04, 32'h10, 32'h7, 5'd3, 1'b1, 1'b1, 16'd0, 16'd1};
        // bne x4,x4 with EX writing x4 -> both forwarded
        vec[2]  = '{32'h0042_1063, 32'h08, 32'h3, 32'h3, 5'd4, 5'd4, 5'd0, 1'b0, 5'd4, 32'hAA, 1'b1, 1'b0, 1'b0,
                    32'h0042_1063, 32'h08, 32'hAA, 32'hAA, 5'd0, 1'b0, 1'b1, 16'd0, 16'd3};
        // same bne, EX writing x0 -> nothing forwarded
        vec[3]  = '{32'h0042_1063, 32'h0C, 32'h3, 32'h3, 5'd4, 5'd4, 5'd0, 1'b0, 5'd0, 32'hAA, 1'b1, 1'b0, 1'b0,
                    32'h0042_1063, 32'h0C, 32'h3, 32'h3, 5'd0, 1'b0, 1'b1, 16'd0, 16'd3};
        // bne x0,x0 with EX "writing" x0 -> x0 never forwarded
        vec[4]  = '{32'h0000_1063, 32'h10, 32'h5, 32'h6, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'hAA, 1'b1, 1'b0, 1'b0,
                    32'h0000_1063, 32'h10, 32'h5, 32'h6, 5'd0, 1'b0, 1'b1, 16'd0, 16'd3};
        // addi x7,x5,6: rs2 field (6) matches EX rd, immediate must survive
        vec[5]  = '{32'h0062_8393, 32'h14, 32'h55, 32'h6, 5'd5, 5'd6, 5'd7, 1'b1, 5'd6, 32'hBB, 1'b1, 1'b0, 1'b0,
                    32'h0062_8393, 32'h14, 32'h55, 32'h6, 5'd7, 1'b1, 1'b1, 16'd0, 16'd3};
        // add with rs1 match but EX not writing
        vec[6]  = '{32'h0020_81B3, 32'h18, 32'h1, 32'h2, 5'd1, 5'd2, 5'd3, 1'b1, 5'd1, 32'hCC, 1'b0, 1'b0, 1'b0,
                    32'h0020_81B3, 32'h18, 32'h1, 32'h2, 5'd3, 1'b1, 1'b1, 16'd0, 16'd3};
        // lw x5,0(x1): load opcode is not in the forwarding set
        vec[7]  = '{32'h0000_A283, 32'h1C, 32'h9, 32'h0, 5'd1, 5'd0, 5'd5, 1'b1, 5'd1, 32'hDD, 1'b1, 1'b0, 1'b0,
                    32'h0000_A283, 32'h1C, 32'h9, 32'h0, 5'd5, 1'b1, 1'b1, 16'd0, 16'd3};
        // add with rs2 only forwarded
        vec[8]  = '{32'h0020_81B3, 32'h20, 32'h1, 32'h2, 5'd1, 5'd2, 5'd3, 1'b1, 5'd2, 32'hEE, 1'b1, 1'b0, 1'b0,
                    32'h0020_81B3, 32'h20, 32'h1, 32'hEE, 5'd3, 1'b1, 1'b1, 16'd0, 16'd4};
        // three hold cycles with changing, forwardable inputs -> frozen
        for (int i = 9; i < 12; i++) begin
            vec[i] = '{32'h0042_1063, 32'h24 + 32'(4 * (i - 9)), 32'h3, 32'h3, 5'd4, 5'd4, 5'd0, 1'b0,
                       5'd4, 32'hAA, 1'b1, 1'b0, 1'b1,
                       32'h0020_81B3, 32'h20, 32'h1, 32'hEE, 5'd3, 1'b1, 1'b1, 16'd0, 16'd4};
        end
        // jump together with hold -> flush wins, no forwarding counted
        vec[12] = '{32'h0042_1063, 32'h30, 32'h3, 32'h3, 5'd4, 5'd4, 5'd0, 1'b0, 5'd4, 32'hAA, 1'b1, 1'b1, 1'b1,
                    32'h0000_0013, 32'h00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 16'd1, 16'd4};
        // jump alone
        vec[13] = '{32'h0020_81B3, 32'h34, 32'h1, 32'h2, 5'd1, 5'd2, 5'd3, 1'b1, 5'd1, 32'hCC, 1'b1, 1'b1, 1'b0,
                    32'h0000_0013, 32'h00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 16'd2, 16'd4};
        // back to a normal load
        vec[14] = '{32'h0050_0093, 32'h38, 32'h0, 32'h5, 5'd0, 5'd5, 5'd1, 1'b1, 5'd1, 32'hFF, 1'b1, 1'b0, 1'b0,
                    32'h0050_0093, 32'h38, 32'h0, 32'h5, 5'd1, 1'b1, 1'b1, 16'd2, 16'd4};

        idle = vec[0];
        idle.jmp = 1'b0;
        idle.hld = 1'b0;
        bne4 = vec[2];

        // ---- reset state ----
        rst = 1'b0;
        drive(idle);
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");

        @(negedge clk);
        rst = 1'b1;

        // ---- table-driven vectors ----
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vec[i]);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.inst", i),  inst_o, vec[i].e_inst);
            chk($sformatf("v%0d.addr", i),  inst_addr_o, vec[i].e_addr);
            chk($sformatf("v%0d.op1", i),   op1_o, vec[i].e_op1);
            chk($sformatf("v%0d.op2", i),   op2_o, vec[i].e_op2);
            chk($sformatf("v%0d.rd", i),    32'(rd_addr_o), 32'(vec[i].e_rd));
            chk($sformatf("v%0d.wen", i),   32'(rd_wen_o), 32'(vec[i].e_wen));
            chk($sformatf("v%0d.valid", i), 32'(valid_o), 32'(vec[i].e_vld));
            chk($sformatf("v%0d.fcnt", i),  32'(flush_cnt_o), 32'(vec[i].e_fc));
            chk($sformatf("v%0d.wcnt", i),  32'(fwd_cnt_o), 32'(vec[i].e_wc));
        end

        // ---- flush counter saturation on the CNT_W=4 instance ----
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("sat.rst_fcnt", 32'(s_flush_cnt_o), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        idle.jmp = 1'b1;
        drive(idle);
        for (int n = 1; n <= 17; n++) begin
            @(posedge clk);
            #1;
            if (n == 14) chk("sat.fcnt14", 32'(s_flush_cnt_o), 32'hE);
            if (n == 15) chk("sat.fcnt15", 32'(s_flush_cnt_o), 32'hF);
            if (n == 17) chk("sat.fcnt17", 32'(s_flush_cnt_o), 32'hF);
        end
        chk("sat.fcnt16bit", 32'(flush_cnt_o), 32'd17);

        // ---- forward counter: +2 from 14 clamps at 15 ----
        @(negedge clk);
        drive(bne4);
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk);
            #1;
            if (n == 7) chk("sat.wcnt7", 32'(s_fwd_cnt_o), 32'hE);
            if (n == 8) chk("sat.wcnt8", 32'(s_fwd_cnt_o), 32'hF);
            if (n == 9) chk("sat.wcnt9", 32'(s_fwd_cnt_o), 32'hF);
        end

        // ---- asynchronous reset pulsed in the middle of a hold ----
        @(negedge clk);
        idle.jmp = 1'b0;
        drive(vec[1]);
        @(posedge clk);
        #1;
        chk("arst.pre_valid", 32'(valid_o), 32'h1);
        @(negedge clk);
        hold_flag_i = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_reset_state("arst");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("arst.hold_inst",  inst_o, 32'h0000_0013);
        chk("arst.hold_valid", 32'(valid_o), 32'h0);
        @(negedge clk);
        hold_flag_i = 1'b0;
        @(posedge clk);
        #1;
        chk("arst.load_inst",  inst_o, 32'h0020_81B3);
        chk("arst.load_op1",   op1_o, 32'h10);
        chk("arst.load_valid", 32'(valid_o), 32'h1);
        chk("arst.load_wcnt",  32'(fwd_cnt_o), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_fwd.md
Name: id_ex_fwd

Overview:
ID/EX pipeline register that sits directly upstream of the execute stage. It captures the decoded instruction and its operands from ID each cycle and presents them to EX. Before capture, it overrides register-file operands with EX's in-flight result when a RAW hazard exists. It also applies jump-flush and hold from ctrl, and keeps saturating flush and forward event counters.

Parameters:
NOP_INST, 32'h0000_0013, instruction word loaded on reset or flush (addi x0,x0,0).
CNT_W, 16, width of the saturating event counters.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
inst_i  input  32  instruction from ID.
inst_addr_i  input  32  instruction address from ID.
op1_i  input  32  operand 1 from ID (rs1 value).
op2_i  input  32  operand 2 from ID (rs2 value or immediate).
rs1_addr_i  input  5  rs1 index of the ID instruction.
rs2_addr_i  input  5  rs2 index of the ID instruction.
rd_addr_i  input  5  destination index from ID.
rd_wen_i  input  1  destination write enable from ID.
ex_rd_addr_i  input  5  EX result destination (combinational EX output).
ex_rd_data_i  input  32  EX result data.
ex_rd_wen_i  input  1  EX result write enable.
jump_en_i  input  1  ctrl jump/flush request.
hold_flag_i  input  1  ctrl stall request.
inst_o  output  32  registered instruction to EX.
inst_addr_o  output  32  registered instruction address to EX.
op1_o  output  32  registered operand 1.
op2_o  output  32  registered operand 2.
rd_addr_o  output  5  registered destination index.
rd_wen_o  output  1  registered write enable.
valid_o  output  1  1 = real instruction held; 0 = bubble.
flush_cnt_o  output  CNT_W  saturating count of flush cycles.
fwd_cnt_o  output  CNT_W  saturating count of forwarded operands.

Behaviour:
- Reset (rst=0, asynchronous): inst_o=NOP_INST; all other data outputs 0; rd_wen_o=0; valid_o=0; both counters 0.
- All outputs are registered. Latency from ID inputs to outputs is one clock.
- Per-edge priority: jump_en_i > hold_flag_i > load.
  - Flush (jump_en_i=1): load the reset values into the data registers, including inst_o=NOP_INST and valid_o=0. Increment flush_cnt_o. This applies even when hold_flag_i=1.
  - Hold (hold_flag_i=1, jump_en_i=0): all pipeline registers keep their values. No forwarding is applied and counters do not change.
  - Load (neither asserted): capture the ID inputs with forwarded operands and set valid_o=1.
- Forwarding decode uses opcode = inst_i[6:0].
  - use_rs1 is true for opcodes 0010011 (I), 0110011 (R) and 1100011 (B).
  - use_rs2 is true for 0110011 and 1100011 only. For I-type, op2_i is an immediate and is never overridden.
- fwd1 = use_rs1 & ex_rd_wen_i & (ex_rd_addr_i != 0) & (ex_rd_addr_i == rs1_addr_i). fwd2 is defined the same way using rs2_addr_i.
- On load: op1 = fwd1 ? ex_rd_data_i : op1_i, and op2 = fwd2 ? ex_rd_data_i : op2_i.
- x0 is never forwarded.
- fwd_cnt_o increases by popcount(fwd1, fwd2) (0, 1 or 2) on load edges only.
- Counters saturate at all-ones and do not wrap. An increment of 2 from all-ones minus 1 saturates at all-ones.
- The ex_* inputs are purely combinational from EX. This block adds no combinational path from ex_* to any output.
- Reset asserted mid-stall or mid-flush takes effect immediately. After release, the first edge follows the normal priority rules.

Test Plan:
- Reset then load addi x1,x0,5 (inst_i=32'h0050_0093, op1_i=0, op2_i=5, rd=1, wen=1) -> next cycle inst_o=32'h0050_0093, op2_o=5, rd_addr_o=1, valid_o=1; during reset inst_o=32'h0000_0013, valid_o=0.
- R-type add x3,x1,x2 with rs1=1, rs2=2, op1_i=0, op2_i=7; ex_rd_addr_i=1, ex_rd_data_i=32'h10, ex_rd_wen_i=1 -> op1_o=32'h10, op2_o=7, fwd_cnt_o +1.
- bne x4,x4 with rs1=rs2=4 and ex_rd_addr_i=4, data 32'hAA -> op1_o=op2_o=32'hAA, fwd_cnt_o +2. Repeat with ex_rd_addr_i=0 -> no forwarding.
- I-type addi where rs2 field equals ex_rd_addr_i=6 and rs1 differs -> op2_o equals the immediate, not forwarded, fwd_cnt_o unchanged.
- hold_flag_i=1 for 3 cycles while inputs change -> outputs frozen. Then jump_en_i=1 together with hold_flag_i=1 -> inst_o=NOP_INST, valid_o=0, flush_cnt_o +1.
- Preload counters near saturation via long flush run (CNT_W=4): 17 flush cycles -> flush_cnt_o=4'hF and stays there. Pulse rst low mid-hold -> all outputs at reset values immediately.
